// File: rtl/stopwatch_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_timer
//
// MM:SS stopwatch / countdown timer driving four active-low seven-segment
// digits. Raw board keys are synchronised and debounced on chip. Each
// debounced press becomes a one-cycle pulse. The pulses drive a
// start/pause state machine. Time is kept in four cascaded BCD digit
// counters, so no divide or modulo logic is needed. A lap function freezes
// the display while counting carries on underneath.
//
// Parameters
//   CLK_HZ        clock cycles per counted second
//   DEBOUNCE_CYC  cycles a synchronised key must stay stable to be accepted
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   key_start_n  raw pushbutton (low = pressed), toggles run / pause
//   key_clear_n  raw pushbutton (low = pressed), clears or loads the preset
//   key_lap_n    raw pushbutton (low = pressed), toggles the lap freeze
//   mode_down    0 = count up, 1 = count down (taken when leaving IDLE)
//   preset_min   countdown start minutes, values above 59 saturate to 59
//   hex0..hex3   active-low segments gfedcba: sec units, sec tens,
//                min units, min tens
//   running      high while in RUN
//   done         high while in DONE
// ---------------------------------------------------------------------------
module stopwatch_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  input  logic       mode_down,
  input  logic [5:0] preset_min,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Segment pattern (gfedcba, active low) for one BCD digit. Codes above 9 blank.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // ------------------------------------------------------------------------
  // Key conditioning. Bit 0 = start, bit 1 = clear, bit 2 = lap.
  // ------------------------------------------------------------------------
  logic [2:0]    keyRaw;
  logic [2:0]    syncA_q;
  logic [2:0]    syncB_q;
  logic [2:0]    debKey_q;
  logic [2:0]    press_q;
  logic [DW-1:0] debCnt_q [3];

  assign keyRaw = {key_lap_n, key_clear_n, key_start_n};

  // Two-flop synchroniser, then a stable-count debouncer per key. The count
  // restarts whenever the synchronised level matches the accepted level. Any
  // bounce therefore restarts the stability window. A press pulse fires only
  // when a low level is accepted; an accepted release produces no pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syncA_q  <= '1;
      syncB_q  <= '1;
      debKey_q <= '1;
      press_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        debCnt_q[k] <= '0;
      end
    end else begin
      syncA_q <= keyRaw;
      syncB_q <= syncA_q;
      for (int k = 0; k < 3; k++) begin
        if (syncB_q[k] == debKey_q[k]) begin
          debCnt_q[k] <= '0;
          press_q[k]  <= 1'b0;
        end else if (debCnt_q[k] == DEB_LAST) begin
          debCnt_q[k] <= '0;
          debKey_q[k] <= syncB_q[k];
          press_q[k]  <= ~syncB_q[k];
        end else begin
          debCnt_q[k] <= debCnt_q[k] + DW'(1);
          press_q[k]  <= 1'b0;
        end
      end
    end
  end

  logic startPulse;
  logic clearPulse;
  logic lapPulse;

  assign startPulse = press_q[0];
  assign clearPulse = press_q[1];
  assign lapPulse   = press_q[2];

  // ------------------------------------------------------------------------
  // Timer state. Digits are packed {min tens, min units, sec tens, sec units}.
  // ------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   snap_q, snap_d;
  logic          lapOn_q, lapOn_d;
  logic          modeDown_q, modeDown_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q;
  logic          running_q, done_q;

  logic          tick;
  logic [15:0]   countUp;
  logic [15:0]   countDown;
  logic          upC0, upC1, upC2;
  logic          dnB0, dnB1, dnB2;
  logic [5:0]    presetSat;
  logic [3:0]    presetTens;
  logic [3:0]    presetUnits;
  logic [15:0]   clearLoad;
  logic [15:0]   shown;

  assign tick = (state_q == RUN) && (presc_q == PRE_LAST);

  // Next value of the time one second later and one second earlier. The
  // digits cascade through their 9/5 limits, so the wrap at 59:59 comes free.
  always_comb begin
    countUp   = count_q;
    countDown = count_q;

    upC0 = (count_q[3:0] == 4'd9);
    upC1 = upC0 && (count_q[7:4] == 4'd5);
    upC2 = upC1 && (count_q[11:8] == 4'd9);
    countUp[3:0] = upC0 ? 4'd0 : count_q[3:0] + 4'd1;
    if (upC0) countUp[7:4]   = (count_q[7:4] == 4'd5)   ? 4'd0 : count_q[7:4] + 4'd1;
    if (upC1) countUp[11:8]  = (count_q[11:8] == 4'd9)  ? 4'd0 : count_q[11:8] + 4'd1;
    if (upC2) countUp[15:12] = (count_q[15:12] == 4'd5) ? 4'd0 : count_q[15:12] + 4'd1;

    dnB0 = (count_q[3:0] == 4'd0);
    dnB1 = dnB0 && (count_q[7:4] == 4'd0);
    dnB2 = dnB1 && (count_q[11:8] == 4'd0);
    countDown[3:0] = dnB0 ? 4'd9 : count_q[3:0] - 4'd1;
    if (dnB0) countDown[7:4]   = (count_q[7:4] == 4'd0)   ? 4'd5 : count_q[7:4] - 4'd1;
    if (dnB1) countDown[11:8]  = (count_q[11:8] == 4'd0)  ? 4'd9 : count_q[11:8] - 4'd1;
    if (dnB2) countDown[15:12] = (count_q[15:12] == 4'd0) ? 4'd5 : count_q[15:12] - 4'd1;
  end

  // Preset minutes to BCD by threshold compare; the range is small enough
  // that a comparator chain is cheaper than a divider.
  always_comb begin
    presetSat = (preset_min > 6'd59) ? 6'd59 : preset_min;
    if (presetSat >= 6'd50)      presetTens = 4'd5;
    else if (presetSat >= 6'd40) presetTens = 4'd4;
    else if (presetSat >= 6'd30) presetTens = 4'd3;
    else if (presetSat >= 6'd20) presetTens = 4'd2;
    else if (presetSat >= 6'd10) presetTens = 4'd1;
    else                         presetTens = 4'd0;
    presetUnits = 4'(presetSat - ({2'b00, presetTens} * 6'd10));
    clearLoad   = mode_down ? {presetTens, presetUnits, 8'h00} : 16'h0000;
  end

  // Next-state logic. Only the highest-priority press acts: clear, then
  // start, then lap. A start in RUN pauses and drops any tick on that edge.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    snap_d     = snap_q;
    lapOn_d    = lapOn_q;
    modeDown_d = modeDown_q;
    presc_d    = presc_q;

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (clearPulse) begin
      state_d = IDLE;
      count_d = clearLoad;
      lapOn_d = 1'b0;
      presc_d = '0;
    end else if (startPulse) begin
      case (state_q)
        IDLE: begin
          if (!(mode_down && (count_q == 16'h0000))) begin
            state_d    = RUN;
            modeDown_d = mode_down;
            presc_d    = '0;
          end
        end
        RUN: begin
          state_d = PAUSE;
          presc_d = presc_q;
        end
        PAUSE: begin
          state_d = RUN;
          presc_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      if (lapPulse && ((state_q == RUN) || (state_q == PAUSE))) begin
        lapOn_d = ~lapOn_q;
        if (!lapOn_q) begin
          snap_d = count_q;
        end
      end
      if (tick) begin
        if (modeDown_q) begin
          count_d = countDown;
          if (countDown == 16'h0000) begin
            state_d = DONE;
          end
        end else begin
          count_d = countUp;
        end
      end
    end
  end

  assign shown = lapOn_q ? snap_q : count_q;

  // State registers. The flags follow the next state so they change on the
  // same edge as the state. The segment outputs lag the digits by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      snap_q     <= '0;
      lapOn_q    <= 1'b0;
      modeDown_q <= 1'b0;
      presc_q    <= '0;
      hex0_q     <= 7'b1000000;
      hex1_q     <= 7'b1000000;
      hex2_q     <= 7'b1000000;
      hex3_q     <= 7'b1000000;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      lapOn_q    <= lapOn_d;
      modeDown_q <= modeDown_d;
      presc_q    <= presc_d;
      hex0_q     <= segOf(shown[3:0]);
      hex1_q     <= segOf(shown[7:4]);
      hex2_q     <= segOf(shown[11:8]);
      hex3_q     <= segOf(shown[15:12]);
      running_q  <= (state_d == RUN);
      done_q     <= (state_d == DONE);
    end
  end

  assign hex0    = hex0_q;
  assign hex1    = hex1_q;
  assign hex2    = hex2_q;
  assign hex3    = hex3_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
